// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - APB slave capturing UART receiver bytes into a FIFO with overrun tracking
// Optional feature macro: UART_RX_IRQ_EN (level interrupt and CTRL[1] irq_en)
module uart_rx_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [3:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    input  logic        rx_done,
    input  logic [7:0]  rx_parallel,
    output logic        irq
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          overrun_q;
    logic          rx_en_q;
    logic          irq_en;

    logic          access, rd_access, wr_access;
    logic          not_empty, full;
    logic          push_req, push_ok, pop, flush;
    logic          ovr_set, ovr_clr, ctrl_wr;
    logic [4:0]    count_ext;
    logic          unused_ok;

    assign PREADY    = 1'b1;
    assign access    = PSEL & PENABLE;
    assign rd_access = access & ~PWRITE;
    assign wr_access = access & PWRITE;

    assign not_empty = (count_q != '0);
    assign full      = (count_q == CW'(DEPTH));
    assign count_ext = 5'(count_q);

    assign ctrl_wr   = wr_access && (PADDR[3:2] == ADDR_CTRL);
    assign flush     = ctrl_wr & PWDATA[2];
    assign pop       = rd_access && (PADDR[3:2] == ADDR_DATA) && not_empty;
    // A push landing in the same cycle as a flush is discarded.
    assign push_req  = rx_done & rx_en_q & ~flush;
    // A simultaneous pop frees a slot, so a full FIFO still accepts the byte.
    assign push_ok   = push_req & (~full | pop);
    assign ovr_set   = push_req & full & ~pop;
    assign ovr_clr   = wr_access && (PADDR[3:2] == ADDR_STATUS) && PWDATA[2];

    assign unused_ok = ^{PADDR[1:0], PWDATA[31:3], PWDATA[1]};

    // FIFO storage is deliberately left without reset.
    always_ff @(posedge PCLK) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= rx_parallel;
        end
    end

    // Pointers, occupancy, sticky overrun and the rx enable.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            rx_en_q   <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push_ok) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
                if (push_ok && !pop) begin
                    count_q <= count_q + CW'(1);
                end else if (pop && !push_ok) begin
                    count_q <= count_q - CW'(1);
                end
            end
            // Set wins over a same-cycle software clear.
            if (ovr_set) begin
                overrun_q <= 1'b1;
            end else if (ovr_clr) begin
                overrun_q <= 1'b0;
            end
            if (ctrl_wr) begin
                rx_en_q <= PWDATA[0];
            end
        end
    end

`ifdef UART_RX_IRQ_EN
    logic irq_en_q;
    logic irq_q;

    // Interrupt enable and registered level interrupt from current state.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                irq_en_q <= PWDATA[1];
            end
            irq_q <= irq_en_q & (not_empty | overrun_q);
        end
    end

    assign irq_en = irq_en_q;
    assign irq    = irq_q;
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif

    // Read mux; drives zero whenever the slave is not selected for a read.
    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            case (PADDR[3:2])
                ADDR_DATA: begin
                    PRDATA[7:0] = not_empty ? mem_q[rd_ptr_q] : 8'h00;
                end
                ADDR_STATUS: begin
                    PRDATA[0]   = not_empty;
                    PRDATA[1]   = full;
                    PRDATA[2]   = overrun_q;
                    PRDATA[8:4] = count_ext;
                end
                ADDR_CTRL: begin
                    PRDATA[0] = rx_en_q;
                    PRDATA[1] = irq_en;
                end
                default: PRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

    logic        PCLK;
    logic        PRESETn;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        rx_done;
    logic [7:0]  rx_parallel;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;

`ifdef UART_RX_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    localparam logic [3:0] A_DATA = 4'h0;
    localparam logic [3:0] A_STAT = 4'h4;
    localparam logic [3:0] A_CTRL = 4'h8;
    localparam logic [3:0] A_RSVD = 4'hC;

    uart_rx_ctrl #(.DEPTH(4)) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .rx_done     (rx_done),
        .rx_parallel (rx_parallel),
        .irq         (irq)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic apb_write(input logic [3:0] addr, input logic [31:0] data);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
        tick();
        PENABLE = 1'b1;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [3:0] addr, input logic with_rx,
                            input logic [7:0] rxb, output logic [31:0] data);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        tick();
        PENABLE = 1'b1;
        if (with_rx) begin
            rx_done = 1'b1; rx_parallel = rxb;
        end
        #2;
        data = PRDATA;
        tick();
        rx_done = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_done = 1'b1; rx_parallel = b;
        tick();
        rx_done = 1'b0;
    endtask

    initial begin
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; rx_done = 1'b0; rx_parallel = '0;
        repeat (3) tick();
        check("reset_pready", 32'(PREADY), 32'h1);
        check("reset_irq", 32'(irq), 32'h0);
        check("reset_prdata", PRDATA, 32'h0);
        PRESETn = 1'b1;
        tick();
        apb_read(A_STAT, 1'b0, 8'h00, rd); check("reset_status", rd, 32'h0);
        apb_read(A_CTRL, 1'b0, 8'h00, rd); check("reset_ctrl", rd, 32'h0);

        // Single byte round trip
        apb_write(A_CTRL, 32'h1);
        rx_byte(8'hA5);
        apb_read(A_STAT, 1'b0, 8'h00, rd); check("one_status", rd, 32'h011);
        apb_read(A_DATA, 1'b0, 8'h00, rd); check("one_data", rd, 32'h0A5);
        apb_read(A_STAT, 1'b0, 8'h00, rd); check("one_status_after", rd, 32'h000);

        // Overrun when full, dropped byte never appears
        rx_byte(8'h01); rx_byte(8'h02); rx_byte(8'h03); rx_byte(8'h04);
        rx_byte(8'h05);
        apb_read(A_STAT, 1'b0, 8'h00, rd); check("ovr_status", rd, 32'h047);
        apb_read(A_DATA, 1'b0, 8'h00, rd); check("ovr_d0", rd, 32'h01);
        apb_read(A_DATA, 1'b0, 8'h00, rd); check("ovr_d1", rd, 32'h02);
        apb_read(A_DATA, 1'b0, 8'h00, rd); check("ovr_d2", rd, 32'h03);
        apb_read(A_DATA, 1'b0, 8'h00, rd); check("ovr_d3", rd, 32'h04);
        apb_read(A_DATA, 1'b0, 8'h00, rd); check("ovr_empty_data", rd, 32'h00);
        apb_read(A_STAT, 1'b0, 8'h00, rd); check("ovr_sticky", rd, 32'h004);
        apb_write(A_STAT, 32'h4);
        apb_read(A_STAT, 1'b0, 8'h00, rd); check("ovr_cleared", rd, 32'h000);

        // Full FIFO: pop and push in the same cycle
        rx_byte(8'h11); rx_byte(8'h12); rx_byte(8'h13); rx_byte(8'h14);
        apb_read(A_STAT, 1'b0, 8'h00, rd); check("full_status", rd, 32'h043);
        apb_read(A_DATA, 1'b1, 8'h77, rd); check("pp_head", rd, 32'h11);
        apb_read(A_STAT, 1'b0, 8'h00, rd); check("pp_status", rd, 32'h043);
        apb_read(A_DATA, 1'b0, 8'h00, rd); check("pp_d1", rd, 32'h12);
        apb_read(A_DATA, 1'b0, 8'h00, rd); check("pp_d2", rd, 32'h13);
        apb_read(A_DATA, 1'b0, 8'h00, rd); check("pp_d3", rd, 32'h14);
        apb_read(A_DATA, 1'b0, 8'h00, rd); check("pp_last", rd, 32'h77);

        // Receiver disabled
        apb_write(A_CTRL, 32'h0);
        rx_byte(8'h3C);
        apb_read(A_STAT, 1'b0, 8'h00, rd); check("dis_status", rd, 32'h000);
        apb_read(A_DATA, 1'b0, 8'h00, rd); check("dis_data", rd, 32'h00);

        // Interrupt path and reserved register
        apb_write(A_CTRL, 32'h3);
        apb_read(A_CTRL, 1'b0, 8'h00, rd); check("ctrl_rw", rd, {30'h0, IRQ_ON, 1'b1});
        rx_byte(8'h10);
        tick();
        check("irq_set", 32'(irq), 32'(IRQ_ON));
        apb_write(A_STAT, 32'h4);
        check("irq_hold", 32'(irq), 32'(IRQ_ON));
        apb_write(A_RSVD, 32'hFFFF_FFFF);
        apb_read(A_RSVD, 1'b0, 8'h00, rd); check("rsvd_read", rd, 32'h0);
        apb_read(A_DATA, 1'b0, 8'h00, rd); check("irq_data", rd, 32'h10);
        tick();
        check("irq_clear", 32'(irq), 32'h0);

        // Flush and async reset
        rx_byte(8'h21); rx_byte(8'h22);
        apb_read(A_STAT, 1'b0, 8'h00, rd); check("two_status", rd, 32'h021);
        apb_write(A_CTRL, 32'h5);
        apb_read(A_STAT, 1'b0, 8'h00, rd); check("flush_status", rd, 32'h000);
        apb_read(A_CTRL, 1'b0, 8'h00, rd); check("flush_ctrl", rd, 32'h1);
        apb_read(A_DATA, 1'b0, 8'h00, rd); check("flush_data", rd, 32'h00);
        apb_write(A_CTRL, 32'h3);
        rx_byte(8'hAB);
        tick();
        check("pre_rst_irq", 32'(irq), 32'(IRQ_ON));
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = A_STAT;
        #1;
        check("pre_rst_status", PRDATA, 32'h011);
        rx_done = 1'b1; rx_parallel = 8'hCD;
        #2;
        PRESETn = 1'b0;
        #1;
        check("arst_status", PRDATA, 32'h000);
        check("arst_irq", 32'(irq), 32'h0);
        PADDR = A_CTRL;
        #1;
        check("arst_ctrl", PRDATA, 32'h000);
        PSEL = 1'b0;
        #1;
        check("arst_prdata", PRDATA, 32'h0);
        check("arst_pready", 32'(PREADY), 32'h1);
        tick();
        rx_done = 1'b0;
        tick();
        PRESETn = 1'b1;
        tick();
        apb_read(A_STAT, 1'b0, 8'h00, rd); check("post_rst_status", rd, 32'h000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

APB-slave controller for the UART receiver path. It captures each byte the receiver flags with its single-cycle done pulse into a small FIFO and tracks overrun. It exposes data, status and control registers to the APB bus, and optionally raises a level interrupt. It sits between the UART receiver instance and the APB interconnect, alongside the GPIO and UART TX slaves.

## Interface
- DEPTH, 4: FIFO depth in bytes; power of two, 2..16.
- PCLK  in  1  system/APB clock; all logic rising-edge.
- PRESETn  in  1  reset; asynchronous assert, active-low.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  4  byte address; only [3:2] decoded.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data; combinational from registers.
- PREADY  out  1  tied 1 (zero wait states).
- rx_done  in  1  receiver byte-valid pulse, one cycle wide.
- rx_parallel  in  8  receiver byte; valid while rx_done=1.
- irq  out  1  level interrupt, registered.

## Operation
- Registers, selected by PADDR[3:2]:
  - 0 DATA (RO): [7:0] is the FIFO head; 0 when empty.
  - 1 STATUS: [0] not_empty, [1] full, [2] overrun (W1C), [8:4] count.
  - 2 CTRL (RW): [0] rx_en, [1] irq_en.
  - 3: reserved; reads 0 and ignores writes.
- Access phase is PSEL & PENABLE. A write commits on that edge. A read returns data in the same cycle.
- Push: rx_done & rx_en.
  - Not full: write rx_parallel at wr_ptr; wr_ptr+1, count+1.
  - Full: drop the byte and set overrun. FIFO contents are unchanged.
- Pop: an access-phase read of DATA while not empty. rd_ptr+1, count-1. A read of DATA while empty returns 0 with no state change.
- Push and pop in the same cycle: both happen and count is unchanged. When full, a simultaneous pop makes room, so the push succeeds with no overrun.
- Pointer widths are log2(DEPTH) and wrap modulo DEPTH. count is log2(DEPTH)+1 bits, so it reaches DEPTH. full = (count==DEPTH).
- Overrun stays set until software writes STATUS with bit 2 = 1. If a set and a clear land in the same cycle, set wins.
- Clearing rx_en:
  - Stops further pushes.
  - FIFO contents remain readable.
  - Contents are not flushed.
- A CTRL write with bit 2 = 1 flushes the FIFO: pointers and count go to 0. Bit 2 is self-clearing and reads 0. A push in the same cycle as a flush is discarded.
- Reset mid-operation returns everything to reset values immediately. A byte in flight is lost.

## Timing
- Reset values:
  - PRDATA = 0 (no select).
  - PREADY = 1.
  - irq = 0.
  - Pointers, count, overrun = 0.
  - rx_en = 0, irq_en = 0.
  - FIFO storage is not reset.
- Push latency: rx_done in cycle N makes not_empty and count visible in cycle N+1.
- Pop: PRDATA shows the head during the access cycle. The next entry is the head from the following cycle.
- A CTRL write takes effect from the next cycle. An rx_done coincident with the write that sets rx_en is ignored.
- irq is updated each edge as irq_en & (not_empty | overrun). It lags the causing event by one cycle.

## Configuration
- UART_RX_IRQ_EN
  - Defined: the irq logic and CTRL[1] are present, as above.
  - Undefined:
    - irq is tied 0.
    - CTRL[1] reads 0 and ignores writes.
    - Other behaviour is unchanged.

## Test plan
- Reset, then set CTRL=0x1 and pulse rx_done with 0xA5 -> next cycle STATUS=0x011; DATA read returns 0xA5; after that STATUS=0x000.
- Enable and push 0x01,0x02,0x03,0x04 (DEPTH=4), then push 0x05 -> STATUS=0x047 (count 4, overrun, full, not_empty); reads return 01..04 and 05 is never returned.
- With the FIFO full, read DATA in the same cycle as rx_done=0x77 -> overrun stays 0, count stays 4, and the last read returns 0x77.
- rx_en=0 with rx_done=0x3C -> count stays 0; a DATA read returns 0x00.
- CTRL=0x3 and push 0x10 -> irq=1 one cycle later. Write STATUS=0x4 with no overrun present -> irq stays 1 until DATA is read, then irq=0 the following cycle.
- Push 2 bytes, write CTRL=0x5 -> count=0 next cycle and CTRL reads 0x1. Assert PRESETn=0 mid-push -> all outputs and status return to reset values asynchronously.
